pll_loop_ctrl: RTL and testbench
================================

# pll_loop_ctrl

Gain-scheduling sequencer for the 24-bit signed phase accumulator (integrator) in the PLL linear model. It takes phase-error samples and produces scaled increments plus a one-cycle clear pulse to the integrator. It runs the loop through clear, acquisition (high gain) and tracking (low gain) states, and maintains a lock/unlock detector that moves between the two gains.

## Interface
Parameters:
- N, 24, data width of error and increment (signed).
- ACQ_SHIFT, 2, arithmetic right shift applied in ACQ; must be ≥1.
- TRK_SHIFT, 6, arithmetic right shift applied in TRACK; must be ≥1 and ≥ ACQ_SHIFT.
- LOCK_THR, 256, in-lock threshold; a sample is in-lock when |err| ≤ LOCK_THR.
- LOCK_CNT, 16, number of consecutive in-lock samples needed to declare lock.
- UNLOCK_CNT, 4, number of consecutive out-of-lock samples needed to drop lock.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  level sampled per cycle; starts or restarts the loop.
- stop  in  1  returns to IDLE; has priority over start.
- err  in  N  signed phase error.
- err_vld  in  1  err is valid this cycle.
- integ_in  out  N  signed increment to the integrator, registered.
- integ_vld  out  1  integ_in is valid; high for one cycle per accepted sample.
- integ_clr  out  1  one-cycle clear pulse to the integrator.
- state  out  2  0=IDLE, 1=CLEAR, 2=ACQ, 3=TRACK.
- locked  out  1  high exactly when state==TRACK.

## Operation
- Reset, applied asynchronously:
  - all outputs 0 and state=IDLE;
  - both run counters cleared.
- IDLE: err ignored, integ_vld=0. start → CLEAR.
- CLEAR: integ_clr=1 for exactly one cycle, counters cleared, err ignored. Next state is ACQ.
- ACQ: each err_vld sample gives integ_in = err >>> ACQ_SHIFT (floor) and integ_vld=1.
  - in-lock sample: in-lock counter increments.
  - out-of-lock sample: in-lock counter clears.
  - the counter reaching LOCK_CNT moves to TRACK and clears the counter.
- TRACK: increment = err >>> TRK_SHIFT.
  - out-of-lock sample: out-of-lock counter increments.
  - in-lock sample: out-of-lock counter clears.
  - the counter reaching UNLOCK_CNT moves to ACQ and clears the counter.
- |err| is computed in N+1 bits, so err = −2^(N−1) counts as out-of-lock and does not wrap.
- Cycles with err_vld=0 leave the counters unchanged and hold integ_in at its last value, with integ_vld=0.
- start while in ACQ or TRACK → CLEAR (restart).
- stop in any state → IDLE, integ_vld=0 from the next cycle.
- start and stop together → IDLE.
- A sample accepted on the cycle of a transition uses the pre-transition state's shift.

## Timing
- Latency from err_vld to integ_vld/integ_in is 1 cycle.
- state, locked and integ_clr are registered and change on the same edge as the integ_in of the triggering sample.
- start to integ_clr=1 takes 1 cycle; ACQ is entered the cycle after that.
- The first sample accepted in ACQ is the one with err_vld on the first ACQ cycle.
- Sustained throughput is one sample per cycle, with no back-pressure.
- RST asserted mid-operation forces the reset values immediately, without waiting for a clock edge. A start pulse issued before RST is not remembered.

## Configuration
- PLL_SHIFT_ROUND_EN defined: increment = (err + 2^(s−1)) >>> s, where s is the active shift. This gives round-half-up, computed in N+1 bits; the result always fits in N bits.
- PLL_SHIFT_ROUND_EN undefined: plain arithmetic shift (floor). No rounding logic is present.

## Test plan
All scenarios use default parameters.
- Reset: RST=1 mid-ACQ with err_vld toggling → outputs immediately 0 and state=0. After RST=0 with no start, the block stays in IDLE.
- Start sequence: a 1-cycle start pulse → next cycle state=1 and integ_clr=1, then state=2 with integ_clr=0. err_vld during CLEAR → no integ_vld.
- ACQ scaling, without macro: err=1000 → integ_in=250; err=−1001 → −251.
- ACQ scaling, with PLL_SHIFT_ROUND_EN: err=−1001 → −250; err=1002 → 251.
- Lock: 15 samples of err=100, then err=300, then 16 samples of err=100:
  - locked rises one cycle after the final sample, state=3;
  - that final sample's integ_in=25;
  - a following err=640 → 10.
- Unlock: in TRACK, 3 samples of err=300, then err=0, then 4 samples of err=−300:
  - still locked after the first three;
  - the drop to state=2, locked=0 happens one cycle after the 4th −300.
  - err=−8388608 is counted as out-of-lock.
- Priority: start and stop both high in TRACK → state=0 next cycle, integ_clr=0.

Source files
------------

// File: rtl/pll_loop_ctrl.sv
// Gain-scheduling sequencer for the PLL phase integrator: IDLE -> CLEAR -> ACQ <-> TRACK.
// Define PLL_SHIFT_ROUND_EN for round-half-up increments instead of floor shifts.
module pll_loop_ctrl #(
    parameter int N          = 24,
    parameter int ACQ_SHIFT  = 2,
    parameter int TRK_SHIFT  = 6,
    parameter int LOCK_THR   = 256,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                stop,
    input  logic signed [N-1:0] err,
    input  logic                err_vld,
    output logic signed [N-1:0] integ_in,
    output logic                integ_vld,
    output logic                integ_clr,
    output logic [1:0]          state,
    output logic                locked
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACQ   = 2'd2,
        TRACK = 2'd3
    } state_t;

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam logic signed [N:0] THR = (N+1)'(LOCK_THR);

    state_t cur, nxt;
    logic [LW-1:0] lock_cnt, lock_cnt_nxt;
    logic [UW-1:0] unlock_cnt, unlock_cnt_nxt;
    logic signed [N:0] err_ext, err_mag;
    logic signed [N-1:0] acq_inc, trk_inc, inc_nxt;
    logic in_lock, lock_hit, unlock_hit, accept, vld_nxt, clr_nxt;

    // Magnitude in N+1 bits so the most negative error cannot wrap into lock
    assign err_ext    = {err[N-1], err};
    assign err_mag    = err_ext[N] ? -err_ext : err_ext;
    assign in_lock    = (err_mag <= THR);
    assign lock_hit   = (lock_cnt == LW'(LOCK_CNT - 1));
    assign unlock_hit = (unlock_cnt == UW'(UNLOCK_CNT - 1));

`ifdef PLL_SHIFT_ROUND_EN
    localparam logic signed [N:0] ACQ_HALF = (N+1)'(1) <<< (ACQ_SHIFT - 1);
    localparam logic signed [N:0] TRK_HALF = (N+1)'(1) <<< (TRK_SHIFT - 1);
    logic signed [N:0] acq_sum, trk_sum, acq_full, trk_full;

    assign acq_sum  = err_ext + ACQ_HALF;
    assign trk_sum  = err_ext + TRK_HALF;
    assign acq_full = acq_sum >>> ACQ_SHIFT;
    assign trk_full = trk_sum >>> TRK_SHIFT;
    assign acq_inc  = acq_full[N-1:0];
    assign trk_inc  = trk_full[N-1:0];
`else
    assign acq_inc = err >>> ACQ_SHIFT;
    assign trk_inc = err >>> TRK_SHIFT;
`endif

    // A restart or stop cycle discards its sample
    assign accept = err_vld && !stop && !start && (cur == ACQ || cur == TRACK);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur        <= IDLE;
            lock_cnt   <= '0;
            unlock_cnt <= '0;
        end else begin
            cur        <= nxt;
            lock_cnt   <= lock_cnt_nxt;
            unlock_cnt <= unlock_cnt_nxt;
        end
    end

    always_comb begin
        nxt            = cur;
        lock_cnt_nxt   = lock_cnt;
        unlock_cnt_nxt = unlock_cnt;
        if (stop) begin
            nxt            = IDLE;
            lock_cnt_nxt   = '0;
            unlock_cnt_nxt = '0;
        end else if (start) begin
            nxt            = CLEAR;
            lock_cnt_nxt   = '0;
            unlock_cnt_nxt = '0;
        end else begin
            case (cur)
                IDLE: ;
                CLEAR: begin
                    nxt            = ACQ;
                    lock_cnt_nxt   = '0;
                    unlock_cnt_nxt = '0;
                end
                ACQ: if (err_vld) begin
                    if (!in_lock)
                        lock_cnt_nxt = '0;
                    else if (lock_hit) begin
                        nxt          = TRACK;
                        lock_cnt_nxt = '0;
                    end else
                        lock_cnt_nxt = lock_cnt + LW'(1);
                end
                TRACK: if (err_vld) begin
                    if (in_lock)
                        unlock_cnt_nxt = '0;
                    else if (unlock_hit) begin
                        nxt            = ACQ;
                        unlock_cnt_nxt = '0;
                    end else
                        unlock_cnt_nxt = unlock_cnt + UW'(1);
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        clr_nxt = (nxt == CLEAR);
        vld_nxt = accept;
        inc_nxt = integ_in;
        if (accept)
            inc_nxt = (cur == TRACK) ? trk_inc : acq_inc;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            integ_in  <= '0;
            integ_vld <= 1'b0;
            integ_clr <= 1'b0;
        end else begin
            integ_in  <= inc_nxt;
            integ_vld <= vld_nxt;
            integ_clr <= clr_nxt;
        end
    end

    assign state  = cur;
    assign locked = (cur == TRACK);

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Directed-vector bench for pll_loop_ctrl: start/clear, scaling, lock/unlock, priority and async reset.
module tb_pll_loop_ctrl;
    localparam int N = 24;

    logic CLK = 1'b0;
    logic RST, start, stop, err_vld;
    logic signed [N-1:0] err;
    logic signed [N-1:0] integ_in;
    logic integ_vld, integ_clr, locked;
    logic [1:0] state;

    pll_loop_ctrl dut (
        .CLK(CLK), .RST(RST), .start(start), .stop(stop), .err(err), .err_vld(err_vld),
        .integ_in(integ_in), .integ_vld(integ_vld), .integ_clr(integ_clr),
        .state(state), .locked(locked)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic                start;
        logic                stop;
        logic signed [N-1:0] err;
        logic                vld;
        logic signed [N-1:0] expIn;
        logic                expVld;
        logic                expClr;
        logic [1:0]          expState;
    } vec_t;

    vec_t vecs[$];
    logic signed [N-1:0] heldIn = '0;
    int applied = 0;
    int miscompares = 0;

`ifdef PLL_SHIFT_ROUND_EN
    localparam int ACQ_NEG1001 = -250;
    localparam int TRK_300     = 5;
`else
    localparam int ACQ_NEG1001 = -251;
    localparam int TRK_300     = 4;
`endif

    // Expected integ_in holds its last valid value on cycles without a sample
    function automatic void add(input logic st, input logic sp, input int e, input logic v,
                                input logic ev, input int ein, input logic ec, input logic [1:0] es);
        vec_t t;
        if (ev) heldIn = N'(ein);
        t.start = st; t.stop = sp; t.err = N'(e); t.vld = v;
        t.expIn = heldIn; t.expVld = ev; t.expClr = ec; t.expState = es;
        vecs.push_back(t);
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        start = v.start; stop = v.stop; err = v.err; err_vld = v.vld;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        applied++;
        if (integ_in !== v.expIn || integ_vld !== v.expVld || integ_clr !== v.expClr ||
            state !== v.expState || locked !== (v.expState == 2'd3)) begin
            miscompares++;
            $display("[TB] FAIL %s: got in=%0d vld=%0b clr=%0b state=%0d locked=%0b, expected in=%0d vld=%0b clr=%0b state=%0d locked=%0b",
                     name, integ_in, integ_vld, integ_clr, state, locked,
                     v.expIn, v.expVld, v.expClr, v.expState, (v.expState == 2'd3));
        end
    endtask

    initial begin
        vec_t z;
        z = '{start:1'b0, stop:1'b0, err:'0, vld:1'b0, expIn:'0, expVld:1'b0, expClr:1'b0, expState:2'd0};

        add(0,0,50,1,     0,0,0,0);
        add(1,0,0,0,      0,0,1,1);
        add(0,0,1000,1,   0,0,0,2);
        add(0,0,1000,1,   1,250,0,2);
        add(0,0,-1001,1,  1,ACQ_NEG1001,0,2);
        add(0,0,77,0,     0,0,0,2);
        for (int i = 0; i < 15; i++) add(0,0,100,1, 1,25,0,2);
        add(0,0,300,1,    1,75,0,2);
        for (int i = 0; i < 16; i++) add(0,0,100,1, 1,25,0,(i == 15) ? 2'd3 : 2'd2);
        add(0,0,640,1,    1,10,0,3);
        add(0,0,0,1,      1,0,0,3);
        for (int i = 0; i < 3; i++) add(0,0,300,1, 1,TRK_300,0,3);
        add(0,0,0,1,      1,0,0,3);
        for (int i = 0; i < 4; i++) add(0,0,-300,1, 1,-5,0,(i == 3) ? 2'd2 : 2'd3);
        for (int i = 0; i < 15; i++) add(0,0,100,1, 1,25,0,2);
        add(0,0,-8388608,1, 1,-2097152,0,2);
        add(0,0,100,1,    1,25,0,2);
        for (int i = 0; i < 15; i++) add(0,0,100,1, 1,25,0,(i == 14) ? 2'd3 : 2'd2);
        add(1,1,100,1,    0,0,0,0);
        add(1,0,0,0,      0,0,1,1);
        add(0,0,0,0,      0,0,0,2);
        add(0,0,100,1,    1,25,0,2);

        RST = 1'b1; start = 1'b0; stop = 1'b0; err = '0; err_vld = 1'b0;
        repeat (2) @(posedge CLK);
        #1 checkOutput(z, "reset_state");
        @(negedge CLK) RST = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges, with a start pulse that must be forgotten
        @(negedge CLK);
        start = 1'b1; err = 24'sd200; err_vld = 1'b1;
        #2 RST = 1'b1;
        #1 checkOutput(z, "async_reset");
        @(negedge CLK);
        start = 1'b0; err_vld = 1'b0;
        @(negedge CLK) RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(z);
            checkOutput(z, $sformatf("post_reset_idle%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
